fifo_push_arbiter: RTL

Round-robin arbiter that shares the single push port of a `fifo` instance between several requesters, e.g. multiple issue/retire sources writing one shared queue. Each requester owns a one-entry staging slot; each cycle the arbiter picks one full slot in round-robin order and drives it onto the FIFO push port, honouring `q_full` and `flush`. It sits directly in front of the FIFO; `fifo_push`/`fifo_data` connect to the FIFO's `push`/`data_in`, and the FIFO's `q_full` is fed back.

---
 rtl/fifo_push_arbiter_if.sv | 44 ++++
 rtl/fifo_push_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fifo_push_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_push_arbiter_if
// Bundles the requester handshake and the FIFO push port shared by
// fifo_push_arbiter and its environment.
//
// Signals:
//   req        NREQ         bit i: requester i presents a word
//   req_data   NREQ*WIDTH   requester i's word at [i*WIDTH +: WIDTH]
//   req_ready  NREQ         bit i: slot i accepts a word this cycle
//   q_full     1            FIFO full flag fed back from the FIFO
//   flush      1            same flush that drives the FIFO
//   fifo_push  1            to FIFO push
//   fifo_data  WIDTH        to FIFO data_in
//   push_src   LOG_NREQ     index of the requester being pushed
//
// Modports:
//   master  the arbiter (drives the FIFO push port and req_ready)
//   slave   the environment (requesters plus FIFO status)
// -----------------------------------------------------------------------------
interface fifo_push_arbiter_if #(
   parameter int LOG_NREQ = 2,
   parameter int WIDTH    = 16
);
   localparam int NREQ = 1 << LOG_NREQ;

   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  q_full;
   logic                  flush;
   logic                  fifo_push;
   logic [WIDTH-1:0]      fifo_data;
   logic [LOG_NREQ-1:0]   push_src;

   modport master (
      input  req, req_data, q_full, flush,
      output req_ready, fifo_push, fifo_data, push_src
   );

   modport slave (
      output req, req_data, q_full, flush,
      input  req_ready, fifo_push, fifo_data, push_src
   );
endinterface

// File: rtl/fifo_push_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_push_arbiter
// Round-robin arbiter sharing the single push port of a FIFO between
// NREQ = 1 << LOG_NREQ requesters. Each requester owns a one-entry staging
// slot; every cycle one full slot is chosen in round-robin order and driven
// onto the FIFO push port, honouring q_full and flush.
//
// Ports:
//   clk           single clock, state updates on posedge
//   rst_n         asynchronous active-low reset
//   bus           fifo_push_arbiter_if.master (requesters + FIFO push port)
//   stall_cycles  16-bit saturating count of edges with a staged word held
//                 back by q_full; present only when FIFO_ARB_STATS_EN is
//                 defined
//
// Build option:
//   FIFO_ARB_STATS_EN  adds the stall_cycles port and its counter.
//
// The push port is combinational from the slot state and q_full/flush so the
// FIFO's acceptance condition (push && !q_full && !flush) always equals
// fifo_push; req_ready includes rst_n so it drops the instant reset asserts.
// -----------------------------------------------------------------------------
module fifo_push_arbiter #(
   parameter int LOG_NREQ = 2,
   parameter int WIDTH    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   fifo_push_arbiter_if.master bus
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [15:0]         stall_cycles
`endif
);

   localparam int NREQ = 1 << LOG_NREQ;

   logic [NREQ-1:0]     valid_r;
   logic [WIDTH-1:0]    slot_r [NREQ];
   logic [LOG_NREQ-1:0] rr_r;

   logic [LOG_NREQ:0]   pick_s;
   logic                grant_s;
   logic [LOG_NREQ-1:0] grant_idx_s;
   logic [NREQ-1:0]     grant_oh_s;
   logic [NREQ-1:0]     ready_s;
   logic [NREQ-1:0]     capture_s;

   // Scans ptr, ptr+1, ... (mod NREQ) and returns {found, first valid index}.
   function automatic logic [LOG_NREQ:0] rr_pick(input logic [NREQ-1:0]     valid,
                                                 input logic [LOG_NREQ-1:0] ptr);
      logic                found;
      logic [LOG_NREQ-1:0] idx;
      logic [LOG_NREQ-1:0] cand;
      found = 1'b0;
      idx   = {LOG_NREQ{1'b0}};
      for (int k = 0; k < NREQ; k++) begin
         // LOG_NREQ-bit addition wraps naturally at NREQ
         cand = ptr + k[LOG_NREQ-1:0];
         if (!found && valid[cand]) begin
            found = 1'b1;
            idx   = cand;
         end else begin
            found = found;
         end
      end
      return {found, idx};
   endfunction

   // Grant selection: nothing may be pushed while the FIFO is full or flushing.
   always_comb begin
      pick_s      = rr_pick(valid_r, rr_r);
      grant_s     = 1'b0;
      grant_idx_s = {LOG_NREQ{1'b0}};
      if (!bus.q_full && !bus.flush) begin
         grant_s     = pick_s[LOG_NREQ];
         grant_idx_s = pick_s[LOG_NREQ-1:0];
      end else begin
         grant_s     = 1'b0;
         grant_idx_s = {LOG_NREQ{1'b0}};
      end
   end

   // Per-slot grant, readiness and capture; a slot being drained may refill.
   always_comb begin
      grant_oh_s = {NREQ{1'b0}};
      ready_s    = {NREQ{1'b0}};
      capture_s  = {NREQ{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         grant_oh_s[i] = grant_s && (grant_idx_s == i[LOG_NREQ-1:0]);
         ready_s[i]    = rst_n && !bus.flush && (!valid_r[i] || grant_oh_s[i]);
         capture_s[i]  = bus.req[i] && ready_s[i];
      end
   end

   // FIFO push port and requester ready outputs.
   always_comb begin
      bus.fifo_push = grant_s;
      bus.push_src  = grant_idx_s;
      bus.req_ready = ready_s;
      if (grant_s) begin
         bus.fifo_data = slot_r[grant_idx_s];
      end else begin
         bus.fifo_data = {WIDTH{1'b0}};
      end
   end

   // Slot occupancy and round-robin pointer; flush drops staged words but keeps rr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= {NREQ{1'b0}};
         rr_r    <= {LOG_NREQ{1'b0}};
      end else if (bus.flush) begin
         valid_r <= {NREQ{1'b0}};
      end else begin
         valid_r <= (valid_r & ~grant_oh_s) | capture_s;
         if (grant_s) begin
            rr_r <= grant_idx_s + LOG_NREQ'(1);
         end
      end
   end

   // Staging slot data capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREQ; i++) begin
            slot_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (capture_s[i]) begin
               slot_r[i] <= bus.req_data[i*WIDTH +: WIDTH];
            end
         end
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [15:0] stall_r;

   // Counts edges where a staged word is held back by a full FIFO; saturates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_r <= 16'h0000;
      end else if ((|valid_r) && bus.q_full && !bus.flush && (stall_r != 16'hFFFF)) begin
         stall_r <= stall_r + 16'h0001;
      end
   end

   assign stall_cycles = stall_r;
`endif

endmodule
